// File: rtl/dm_pkg.sv
// Shared debug-module types for the DTM data-register stage: DMI op/error
// encodings, request/response payloads and the DTMCS field layout.
package dm_pkg;

    localparam int unsigned DmiAddrWidth = 7;
    localparam logic [3:0]  DtmVersion   = 4'd1;

    typedef enum logic [1:0] {
        DtmNop   = 2'd0,
        DtmRead  = 2'd1,
        DtmWrite = 2'd2
    } dtm_op_e;

    typedef enum logic [1:0] {
        DmiNoError = 2'd0,
        DmiFailed  = 2'd2,
        DmiBusy    = 2'd3
    } dmi_error_e;

    typedef struct packed {
        logic [DmiAddrWidth-1:0] addr;
        dtm_op_e                 op;
        logic [31:0]             data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    typedef struct packed {
        logic [13:0] zero1;
        logic        dmihardreset;
        logic        dmireset;
        logic        zero0;
        logic [2:0]  idle;
        logic [1:0]  dmistat;
        logic [5:0]  abits;
        logic [3:0]  version;
    } dtmcs_t;

endpackage

// File: rtl/dmi_jtag_dr.sv
// TCK-domain DTM stage: DTMCS/DMI shift registers plus the FSM that turns
// completed DMI scans into request/response handshakes toward the DMI CDC.
module dmi_jtag_dr
    import dm_pkg::*;
#(
    parameter int unsigned AddrWidth  = DmiAddrWidth,
    parameter logic [2:0]  IdleCycles = 3'd1
) (
    input  logic      tck_i,
    input  logic      trst_ni,
    input  logic      dmi_clear_i,
    input  logic      capture_i,
    input  logic      shift_i,
    input  logic      update_i,
    input  logic      tdi_i,
    input  logic      dtmcs_select_i,
    output logic      dtmcs_tdo_o,
    input  logic      dmi_select_i,
    output logic      dmi_tdo_o,
    output logic      dmi_req_valid_o,
    input  logic      dmi_req_ready_i,
    output dmi_req_t  dmi_req_o,
    input  logic      dmi_resp_valid_i,
    output logic      dmi_resp_ready_o,
    input  dmi_resp_t dmi_resp_i,
    output logic      dmi_rst_no
);

    localparam int unsigned DrWidth = AddrWidth + 34;

    typedef enum logic [2:0] {
        Idle,
        Read,
        WaitReadValid,
        Write,
        WaitWriteValid
    } state_e;

    state_e                 state_q;
    dmi_error_e             error_q;
    logic [AddrWidth-1:0]   address_q;
    logic [31:0]            data_q;
    logic [DrWidth-1:0]     dr_q;
    dtmcs_t                 dtmcs_q;
    dtmcs_t                 dtmcs_capture;
    logic                   dmi_rst_nq;

    logic [AddrWidth-1:0]   dr_addr;
    logic [31:0]            dr_data;
    dtm_op_e                dr_op;
    logic                   hard_reset;
    logic                   dmi_reset;
    logic                   busy_hit;
    logic                   dmi_update;

    assign dr_addr = dr_q[DrWidth-1:34];
    assign dr_data = dr_q[33:2];
    assign dr_op   = dtm_op_e'(dr_q[1:0]);

    // A TAP reset (dmi_clear_i) behaves exactly like a dmihardreset write.
    assign hard_reset = dmi_clear_i | (update_i & dtmcs_select_i & dtmcs_q.dmihardreset);
    assign dmi_reset  = update_i & dtmcs_select_i & dtmcs_q.dmireset;
    assign busy_hit   = (capture_i | update_i) & dmi_select_i & (state_q != Idle);
    assign dmi_update = update_i & dmi_select_i;

    always_comb begin
        dtmcs_capture              = '0;
        dtmcs_capture.version      = DtmVersion;
        dtmcs_capture.abits        = 6'(AddrWidth);
        dtmcs_capture.dmistat      = error_q;
        dtmcs_capture.idle         = IdleCycles;
    end

    assign dmi_tdo_o   = dr_q[0];
    assign dtmcs_tdo_o = dtmcs_q[0];
    assign dmi_rst_no  = dmi_rst_nq;

    assign dmi_req_valid_o  = (state_q == Read) || (state_q == Write);
    assign dmi_resp_ready_o = (state_q == WaitReadValid) || (state_q == WaitWriteValid);

    always_comb begin
        dmi_req_o      = '0;
        dmi_req_o.addr = address_q;
        dmi_req_o.data = data_q;
        unique case (state_q)
            Read, WaitReadValid:   dmi_req_o.op = DtmRead;
            Write, WaitWriteValid: dmi_req_o.op = DtmWrite;
            default:               dmi_req_o.op = DtmNop;
        endcase
    end

    // Shift registers are only touched by the TAP strobes, never by hard reset.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            dr_q    <= '0;
            dtmcs_q <= '0;
        end else begin
            if (dmi_select_i) begin
                if (capture_i) begin
                    dr_q <= {address_q, data_q, error_q};
                end else if (shift_i) begin
                    dr_q <= {tdi_i, dr_q[DrWidth-1:1]};
                end
            end
            if (dtmcs_select_i) begin
                if (capture_i) begin
                    dtmcs_q <= dtmcs_capture;
                end else if (shift_i) begin
                    dtmcs_q <= dtmcs_t'({tdi_i, dtmcs_q[31:1]});
                end
            end
        end
    end

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q    <= Idle;
            error_q    <= DmiNoError;
            address_q  <= '0;
            data_q     <= '0;
            dmi_rst_nq <= 1'b1;
        end else if (hard_reset) begin
            state_q    <= Idle;
            error_q    <= DmiNoError;
            address_q  <= '0;
            data_q     <= '0;
            dmi_rst_nq <= 1'b0;
        end else begin
            dmi_rst_nq <= 1'b1;
            if (dmi_reset) begin
                error_q <= DmiNoError;
            end
            unique case (state_q)
                Idle: begin
                    if (dmi_update && error_q == DmiNoError) begin
                        address_q <= dr_addr;
                        data_q    <= dr_data;
                        if (dr_op == DtmRead) begin
                            state_q <= Read;
                        end else if (dr_op == DtmWrite) begin
                            state_q <= Write;
                        end
                    end
                end
                Read: begin
                    if (dmi_req_ready_i) state_q <= WaitReadValid;
                end
                Write: begin
                    if (dmi_req_ready_i) state_q <= WaitWriteValid;
                end
                WaitReadValid: begin
                    if (dmi_resp_valid_i) begin
                        state_q <= Idle;
                        data_q  <= dmi_resp_i.data;
                        if (dmi_resp_i.resp != 2'd0) error_q <= DmiFailed;
                    end
                end
                WaitWriteValid: begin
                    if (dmi_resp_valid_i) begin
                        state_q <= Idle;
                        if (dmi_resp_i.resp != 2'd0) error_q <= DmiFailed;
                    end
                end
                default: state_q <= Idle;
            endcase
            // Busy is decided on the pre-edge state and only when no error is latched yet.
            if (busy_hit && error_q == DmiNoError) begin
                error_q <= DmiBusy;
            end
        end
    end

endmodule

// File: tb/tb_dmi_jtag_dr.sv
// Directed-plus-random bench for dmi_jtag_dr: drives full TAP scans and checks
// requests, scan-out contents and DTMCS status against a simple expected model.
module tb_dmi_jtag_dr;
    import dm_pkg::*;

    localparam int AW  = 7;
    localparam int DRW = AW + 34;

    logic      tck_i = 1'b0;
    logic      trst_ni = 1'b0;
    logic      dmi_clear_i = 1'b0;
    logic      capture_i = 1'b0;
    logic      shift_i = 1'b0;
    logic      update_i = 1'b0;
    logic      tdi_i = 1'b0;
    logic      dtmcs_select_i = 1'b0;
    logic      dtmcs_tdo_o;
    logic      dmi_select_i = 1'b0;
    logic      dmi_tdo_o;
    logic      dmi_req_valid_o;
    logic      dmi_req_ready_i = 1'b1;
    dmi_req_t  dmi_req_o;
    logic      dmi_resp_valid_i = 1'b0;
    logic      dmi_resp_ready_o;
    dmi_resp_t dmi_resp_i = '0;
    logic      dmi_rst_no;

    dmi_jtag_dr #(.AddrWidth(AW), .IdleCycles(3'd1)) dut (
        .tck_i            (tck_i),
        .trst_ni          (trst_ni),
        .dmi_clear_i      (dmi_clear_i),
        .capture_i        (capture_i),
        .shift_i          (shift_i),
        .update_i         (update_i),
        .tdi_i            (tdi_i),
        .dtmcs_select_i   (dtmcs_select_i),
        .dtmcs_tdo_o      (dtmcs_tdo_o),
        .dmi_select_i     (dmi_select_i),
        .dmi_tdo_o        (dmi_tdo_o),
        .dmi_req_valid_o  (dmi_req_valid_o),
        .dmi_req_ready_i  (dmi_req_ready_i),
        .dmi_req_o        (dmi_req_o),
        .dmi_resp_valid_i (dmi_resp_valid_i),
        .dmi_resp_ready_o (dmi_resp_ready_o),
        .dmi_resp_i       (dmi_resp_i),
        .dmi_rst_no       (dmi_rst_no)
    );

    always #5 tck_i = ~tck_i;

    int checks = 0;
    int failures = 0;
    int beats = 0;
    int rst_low = 0;
    logic [DRW-1:0] last_req = '0;

    // Handshake and reset-pulse observers, using pre-edge values.
    always @(posedge tck_i) begin
        if (trst_ni && dmi_req_valid_o && dmi_req_ready_i) begin
            beats    <= beats + 1;
            last_req <= dmi_req_o;
        end
        if (trst_ni && !dmi_rst_no) rst_low <= rst_low + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic dmi_scan(input logic [DRW-1:0] din, input bit do_upd, output logic [DRW-1:0] dout);
        @(negedge tck_i);
        dmi_select_i = 1'b1;
        capture_i = 1'b1;
        @(negedge tck_i);
        capture_i = 1'b0;
        for (int i = 0; i < DRW; i++) begin
            shift_i = 1'b1;
            tdi_i = din[i];
            dout[i] = dmi_tdo_o;
            @(negedge tck_i);
        end
        shift_i = 1'b0;
        tdi_i = 1'b0;
        if (do_upd) begin
            update_i = 1'b1;
            @(negedge tck_i);
            update_i = 1'b0;
        end
        dmi_select_i = 1'b0;
    endtask

    task automatic dtmcs_scan(input logic [31:0] din, input bit do_upd, output logic [31:0] dout);
        @(negedge tck_i);
        dtmcs_select_i = 1'b1;
        capture_i = 1'b1;
        @(negedge tck_i);
        capture_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            shift_i = 1'b1;
            tdi_i = din[i];
            dout[i] = dtmcs_tdo_o;
            @(negedge tck_i);
        end
        shift_i = 1'b0;
        tdi_i = 1'b0;
        if (do_upd) begin
            update_i = 1'b1;
            @(negedge tck_i);
            update_i = 1'b0;
        end
        dtmcs_select_i = 1'b0;
    endtask

    task automatic wait_resp_ready(input string tag);
        int n = 0;
        while (!dmi_resp_ready_o && n < 20) begin
            @(negedge tck_i);
            n++;
        end
        chk(tag, 64'(dmi_resp_ready_o), 64'd1);
    endtask

    task automatic respond(input logic [31:0] rdata, input logic [1:0] rr);
        wait_resp_ready("resp_ready_wait");
        dmi_resp_valid_i = 1'b1;
        dmi_resp_i.data = rdata;
        dmi_resp_i.resp = rr;
        @(negedge tck_i);
        dmi_resp_valid_i = 1'b0;
        dmi_resp_i = '0;
    endtask

    // Expected DTMCS capture: version 1, abits 7, idle 1, dmistat in [11:10].
    function automatic logic [31:0] dtmcs_exp(input logic [1:0] err);
        return 32'd1 + (32'd7 << 4) + (32'd1 << 12) + (32'(err) << 10);
    endfunction

    initial begin
        logic [31:0]    dv;
        logic [DRW-1:0] rv;
        logic [AW-1:0]  addr, exp_addr;
        logic [31:0]    data, rdata, exp_data;
        logic [1:0]     op;
        int             b0, r0;

        exp_addr = '0;
        exp_data = '0;

        repeat (3) @(negedge tck_i);
        chk("reset_rst_no", 64'(dmi_rst_no), 64'd1);
        chk("reset_req_valid", 64'(dmi_req_valid_o), 64'd0);
        chk("reset_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
        chk("reset_dmi_tdo", 64'(dmi_tdo_o), 64'd0);
        chk("reset_dtmcs_tdo", 64'(dtmcs_tdo_o), 64'd0);
        trst_ni = 1'b1;

        dtmcs_scan(32'd0, 1'b1, dv);
        chk("dtmcs_after_reset", 64'(dv), 64'h0000_1071);
        dmi_scan('0, 1'b0, rv);
        chk("dmi_capture_reset", 64'(rv), 64'd0);

        // Transactions: a directed write, a directed read, then random ones.
        for (int t = 0; t < 8; t++) begin
            if (t == 0) begin
                addr = 7'h10; data = 32'hDEAD_BEEF; op = 2'd2; rdata = $urandom;
            end else if (t == 1) begin
                addr = 7'h11; data = $urandom; op = 2'd1; rdata = 32'h1234_5678;
            end else begin
                addr = 7'($urandom_range(0, 127)); data = $urandom;
                op = 2'($urandom_range(1, 2)); rdata = $urandom;
            end
            b0 = beats;
            dmi_scan({addr, data, op}, 1'b1, rv);
            repeat (2) @(negedge tck_i);
            chk("req_beats", 64'(beats - b0), 64'd1);
            chk("req_payload", 64'(last_req), 64'({addr, op, data}));
            respond(rdata, 2'd0);
            exp_addr = addr;
            exp_data = (op == 2'd1) ? rdata : data;
            dmi_scan('0, 1'b0, rv);
            chk("dmi_capture_after_txn", 64'(rv), 64'({exp_addr, exp_data, 2'd0}));
            $display("txn %0d op=%0d addr=0x%0h data=0x%0h rdata=0x%0h", t, op, addr, data, rdata);
        end

        // Busy: request stalled while a second update arrives.
        dmi_req_ready_i = 1'b0;
        addr = 7'($urandom_range(0, 127)); data = $urandom;
        b0 = beats;
        dmi_scan({addr, data, 2'd2}, 1'b1, rv);
        repeat (3) @(negedge tck_i);
        chk("busy_req_valid_held", 64'(dmi_req_valid_o), 64'd1);
        dmi_scan({~addr, ~data, 2'd2}, 1'b1, rv);
        chk("busy_payload_stable", 64'(dmi_req_o), 64'({addr, 2'd2, data}));
        chk("busy_no_beat", 64'(beats - b0), 64'd0);
        dtmcs_scan(32'd0, 1'b1, dv);
        chk("busy_dmistat", 64'(dv), 64'(dtmcs_exp(2'd3)));
        dmi_req_ready_i = 1'b1;
        repeat (2) @(negedge tck_i);
        chk("busy_single_beat", 64'(beats - b0), 64'd1);
        chk("busy_beat_payload", 64'(last_req), 64'({addr, 2'd2, data}));
        respond($urandom, 2'd0);
        dtmcs_scan(32'h0001_0000, 1'b1, dv);
        chk("busy_sticky", 64'(dv), 64'(dtmcs_exp(2'd3)));
        dtmcs_scan(32'd0, 1'b1, dv);
        chk("dmireset_clears_busy", 64'(dv), 64'(dtmcs_exp(2'd0)));
        exp_addr = addr; exp_data = data;
        dmi_scan('0, 1'b0, rv);
        chk("busy_update_ignored", 64'(rv), 64'({exp_addr, exp_data, 2'd0}));
        $display("txn busy addr=0x%0h data=0x%0h", addr, data);

        // Failed response blocks further updates until dmireset.
        addr = 7'($urandom_range(0, 127)); data = $urandom;
        dmi_scan({addr, data, 2'd2}, 1'b1, rv);
        respond($urandom, 2'd2);
        dtmcs_scan(32'd0, 1'b1, dv);
        chk("failed_dmistat", 64'(dv), 64'(dtmcs_exp(2'd2)));
        b0 = beats;
        dmi_scan({~addr, ~data, 2'd1}, 1'b1, rv);
        repeat (3) @(negedge tck_i);
        chk("failed_update_no_beat", 64'(beats - b0), 64'd0);
        chk("failed_no_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
        dmi_scan('0, 1'b0, rv);
        chk("failed_capture", 64'(rv), 64'({addr, data, 2'd2}));
        dtmcs_scan(32'h0001_0000, 1'b1, dv);
        dtmcs_scan(32'd0, 1'b1, dv);
        chk("dmireset_clears_failed", 64'(dv), 64'(dtmcs_exp(2'd0)));
        $display("txn failed addr=0x%0h data=0x%0h", addr, data);

        // dmihardreset in the middle of a read.
        addr = 7'($urandom_range(1, 127)); data = $urandom | 32'h1;
        dmi_scan({addr, data, 2'd1}, 1'b1, rv);
        wait_resp_ready("hr_wait_read");
        r0 = rst_low;
        dtmcs_scan(32'h0002_0000, 1'b1, dv);
        chk("hr_resp_ready_drop", 64'(dmi_resp_ready_o), 64'd0);
        repeat (3) @(negedge tck_i);
        chk("hr_rst_pulse_len", 64'(rst_low - r0), 64'd1);
        chk("hr_req_valid", 64'(dmi_req_valid_o), 64'd0);
        dmi_scan('0, 1'b0, rv);
        chk("hr_capture_zero", 64'(rv), 64'd0);
        $display("txn hardreset addr=0x%0h", addr);

        // dmi_clear_i mid-read, with the error also set beforehand.
        dmi_scan({addr, data, 2'd1}, 1'b1, rv);
        wait_resp_ready("clr_wait_read");
        dmi_scan({addr, data, 2'd1}, 1'b0, rv);
        r0 = rst_low;
        @(negedge tck_i);
        dmi_clear_i = 1'b1;
        @(negedge tck_i);
        dmi_clear_i = 1'b0;
        chk("clr_resp_ready_drop", 64'(dmi_resp_ready_o), 64'd0);
        repeat (3) @(negedge tck_i);
        chk("clr_rst_pulse_len", 64'(rst_low - r0), 64'd1);
        dmi_scan('0, 1'b0, rv);
        chk("clr_capture_zero", 64'(rv), 64'd0);
        dtmcs_scan(32'd0, 1'b1, dv);
        chk("clr_dmistat", 64'(dv), 64'(dtmcs_exp(2'd0)));
        $display("txn clear addr=0x%0h", addr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
